icache_refill_ctrl: RTL
=======================

Name: icache_refill_ctrl

Overview:
- Miss-handling sequencer for the L1 instruction cache in fetch stage 1.
- Captures a cache miss and issues one block-read request to the lower memory level.
- Assembles the returned beats into a full cache block, then drives the cache write port (write enable, write address, block data) for exactly one cycle.
- Handles fetch redirects (flush) that arrive while a refill is in flight.

Parameters:
- ADDR_W, 32: address width; equals the PC width.
- BLOCK_W, 256: cache block width in bits; must be a power of two.
- MEM_W, 64: memory response beat width in bits; BLOCK_W must be a multiple of MEM_W.
- Derived, not overridable: BEATS = BLOCK_W/MEM_W; OFFSET_BITS = log2(BLOCK_W/8) = 5; BEAT_CNT_W = max(1, log2(BEATS)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- miss_i  in  1  cache lookup missed this cycle.
- missAddr_i  in  ADDR_W  address of the miss.
- flush_i  in  1  fetch redirect; the pending refill is abandoned.
- memReq_o  out  1  request valid.
- memReqAddr_o  out  ADDR_W  block-aligned request address.
- memReqRdy_i  in  1  memory accepts the request.
- memRspValid_i  in  1  response beat valid.
- memRspData_i  in  MEM_W  response beat data.
- wrEnable_o  out  1  cache write strobe.
- wrAddr_o  out  ADDR_W  block-aligned write address.
- instBlock_o  out  BLOCK_W  assembled block.
- busy_o  out  1  state is not IDLE.
- refillCount_o  out  32  completed refills (see Optional Feature).
- missCycles_o  out  32  busy cycles (see Optional Feature).

Behaviour:
- Reset: state = IDLE; beat counter = 0; all outputs = 0, including instBlock_o and wrAddr_o. Reset mid-refill returns to IDLE immediately. Memory is reset by the same reset, so no drain is needed.
- State IDLE:
  - If miss_i & ~flush_i: latch addr = missAddr_i with low OFFSET_BITS bits cleared; go to REQ.
  - If flush_i is high the same cycle, the miss is ignored.
- State REQ:
  - memReq_o = 1; memReqAddr_o = latched addr, held stable until accepted.
  - If memReqRdy_i & ~flush_i: go to FILL; beat counter = 0.
  - If flush_i and not accepted: go to IDLE; the request is withdrawn.
  - If flush_i and memReqRdy_i in the same cycle: request counts as accepted; go to DROP.
- State FILL:
  - On each memRspValid_i: write memRspData_i into block slice [cnt*MEM_W +: MEM_W]; increment cnt. Beat 0 occupies the LSBs.
  - On the beat with cnt == BEATS-1: go to WRITE.
  - If flush_i (with or without a beat that cycle): go to DROP, keeping the current cnt. A beat arriving that cycle is counted.
- State DROP:
  - Consume the remaining beats without storing them.
  - After the last beat: go to IDLE; no write.
  - Further flush_i has no effect.
- State WRITE:
  - Exactly one cycle: wrEnable_o = 1, wrAddr_o = latched addr, instBlock_o = assembled block.
  - flush_i does not suppress the write; the data is valid.
  - miss_i is ignored this cycle; go to IDLE.
- wrAddr_o and instBlock_o hold their last values outside WRITE. Only wrEnable_o qualifies them.
- Minimum latency: miss_i in cycle 0 → memReq_o in cycle 1. With memReqRdy_i in cycle 1 and beats in cycles 2..5 (BEATS = 4), wrEnable_o is asserted in cycle 6.
- Only one outstanding refill at a time. No request merging; a repeat miss to the same block after WRITE starts a new refill.
- memRspValid_i in IDLE, REQ or WRITE is a protocol error. It is ignored and does not change state.
- Stalls from fetch do not affect the controller; refill proceeds while fetch is stalled.

Optional Feature:
- Macro: ICACHE_REFILL_PERF_EN.
- Defined:
  - refillCount_o increments on each WRITE cycle.
  - missCycles_o increments on every cycle with busy_o = 1.
  - Both are 32-bit, wrap at 2^32-1 → 0, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Test Plan:
- Basic refill:
  - Stimulus: miss 0x0000_1234; memReqRdy_i = 1 immediately; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back.
  - Required: memReqAddr_o = 0x0000_1220; wrEnable_o one cycle in cycle 6; wrAddr_o = 0x1220; instBlock_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Backpressure and gaps:
  - Stimulus: memReqRdy_i low for 3 cycles; beats separated by 2 idle cycles.
  - Required: memReq_o and memReqAddr_o held stable throughout; correct block; single write.
- Flush in REQ:
  - Stimulus: flush_i while memReqRdy_i = 0.
  - Required: memReq_o drops the next cycle; IDLE; no write; busy_o = 0.
- Flush in FILL:
  - Stimulus: flush_i after beat 1.
  - Required: DROP consumes beats 2-3; wrEnable_o never asserted; a new miss afterwards refills normally.
- Reset mid-FILL:
  - Stimulus: reset after beat 2.
  - Required: all outputs 0 next cycle; IDLE.
- Perf counters (with ICACHE_REFILL_PERF_EN):
  - Stimulus: three basic refills.
  - Required: refillCount_o = 3; missCycles_o = 18.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache refill sequencer: one block-read per miss, beat assembly, one-cycle cache write.
// Optional performance counters are enabled by defining ICACHE_REFILL_PERF_EN.
module icache_refill_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256,
  parameter int MEM_W   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_i,
  input  logic [ADDR_W-1:0]  missAddr_i,
  input  logic               flush_i,
  output logic               memReq_o,
  output logic [ADDR_W-1:0]  memReqAddr_o,
  input  logic               memReqRdy_i,
  input  logic               memRspValid_i,
  input  logic [MEM_W-1:0]   memRspData_i,
  output logic               wrEnable_o,
  output logic [ADDR_W-1:0]  wrAddr_o,
  output logic [BLOCK_W-1:0] instBlock_o,
  output logic               busy_o,
  output logic [31:0]        refillCount_o,
  output logic [31:0]        missCycles_o
);

  localparam int BEATS       = BLOCK_W / MEM_W;
  localparam int OFFSET_BITS = $clog2(BLOCK_W / 8);
  localparam int BEAT_CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, REQ, FILL, DROP, WRITE} state_t;

  state_t                  state, stateNext;
  logic [BEAT_CNT_W-1:0]   cnt, cntNext;
  logic [ADDR_W-1:0]       addr;
  logic [BLOCK_W-1:0]      fillBuf;
  logic [BLOCK_W-1:0]      assembled;
  logic                    lastBeat;
  logic                    unusedAddrBits;

  assign unusedAddrBits = ^missAddr_i[OFFSET_BITS-1:0];
  assign lastBeat       = memRspValid_i && (cnt == BEAT_CNT_W'(BEATS - 1));

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: if (miss_i && !flush_i) stateNext = REQ;
      REQ: begin
        if (memReqRdy_i) begin
          cntNext   = '0;
          stateNext = flush_i ? DROP : FILL;
        end else if (flush_i) begin
          stateNext = IDLE;
        end
      end
      FILL: begin
        if (memRspValid_i) cntNext = cnt + BEAT_CNT_W'(1);
        // A flush on the final beat leaves nothing outstanding, so there is nothing left to drop.
        if (flush_i)       stateNext = lastBeat ? IDLE : DROP;
        else if (lastBeat) stateNext = WRITE;
      end
      DROP: begin
        if (memRspValid_i) cntNext = cnt + BEAT_CNT_W'(1);
        if (lastBeat)      stateNext = IDLE;
      end
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    assembled = fillBuf;
    assembled[int'(cnt) * MEM_W +: MEM_W] = memRspData_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      addr        <= '0;
      wrAddr_o    <= '0;
      instBlock_o <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (state == IDLE && miss_i && !flush_i)
        addr <= {missAddr_i[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      if (state == FILL && lastBeat && !flush_i) begin
        wrAddr_o    <= addr;
        instBlock_o <= assembled;
      end
    end
  end

  // NOTE: the beat buffer is pure datapath, fully rewritten each refill, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == FILL && memRspValid_i) fillBuf <= assembled;
  end

  assign memReq_o     = (state == REQ);
  assign memReqAddr_o = addr;
  assign wrEnable_o   = (state == WRITE);
  assign busy_o       = (state != IDLE);

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] refillCount, missCycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      refillCount <= '0;
      missCycles  <= '0;
    end else begin
      if (state == WRITE) refillCount <= refillCount + 32'd1;
      if (busy_o)         missCycles  <= missCycles + 32'd1;
    end
  end

  assign refillCount_o = refillCount;
  assign missCycles_o  = missCycles;
`else
  assign refillCount_o = 32'd0;
  assign missCycles_o  = 32'd0;
`endif

endmodule
